// File: rtl/csel_adder_pipe_if.sv
// Handshake and data bundle for csel_adder_pipe.
// The ovf signal exists only when CSEL_ADDER_OVF_EN is defined.
interface csel_adder_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef CSEL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder, one BLOCK-wide slice per stage, valid/ready at both ends.
// Define CSEL_ADDER_OVF_EN to add the pipelined signed-overflow output bus.ovf.
module csel_adder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned BLOCK = 4
) (
    input logic              clk,
    input logic              reset,
    csel_adder_pipe_if.slave bus
);
    localparam int unsigned NSTAGE = WIDTH / BLOCK;

    logic stall;

    // Whole pipe freezes while the output is held; bubbles stay in place.
    assign stall        = bus.out_valid && !bus.out_ready;
    assign bus.in_ready = !stall;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int unsigned REM  = WIDTH - k * BLOCK;
        localparam int unsigned DONE = (k + 1) * BLOCK;

        logic [REM-1:0]  a_in;
        logic [REM-1:0]  b_in;
        logic            c_in;
        logic            v_in;
        logic [BLOCK:0]  sum0;
        logic [BLOCK:0]  sum1;
        logic [BLOCK-1:0] blk_sel;
        logic [DONE-1:0] sum_d;
        logic [DONE-1:0] sum_q;
        logic            carry_d;
        logic            carry_q;
        logic            valid_q;

        if (k == 0) begin : g_head
            assign a_in  = bus.a;
            assign b_in  = bus.b;
            assign c_in  = bus.cin;
            assign v_in  = bus.in_valid;
            assign sum_d = blk_sel;
        end else begin : g_body
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].carry_q;
            assign v_in  = g_stage[k-1].valid_q;
            assign sum_d = {blk_sel, g_stage[k-1].sum_q};
        end

        // Both candidate sums are ready before the incoming carry selects one.
        assign sum0    = {1'b0, a_in[BLOCK-1:0]} + {1'b0, b_in[BLOCK-1:0]};
        assign sum1    = {1'b0, a_in[BLOCK-1:0]} + {1'b0, b_in[BLOCK-1:0]}
                       + {{BLOCK{1'b0}}, 1'b1};
        assign blk_sel = c_in ? sum1[BLOCK-1:0] : sum0[BLOCK-1:0];
        assign carry_d = c_in ? sum1[BLOCK] : sum0[BLOCK];

        always_ff @(posedge clk) begin
            if (reset) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (!stall) begin
                valid_q <= v_in;
                sum_q   <= sum_d;
                carry_q <= carry_d;
            end
        end

        // Only the operand bits later stages still need are carried forward.
        if (REM > BLOCK) begin : g_fwd
            logic [REM-BLOCK-1:0] a_q;
            logic [REM-BLOCK-1:0] b_q;

            always_ff @(posedge clk) begin
                if (!stall) begin
                    a_q <= a_in[REM-1:BLOCK];
                    b_q <= b_in[REM-1:BLOCK];
                end
            end
        end
    end

    assign bus.out_valid = g_stage[NSTAGE-1].valid_q;
    assign bus.sum       = g_stage[NSTAGE-1].sum_q;
    assign bus.cout      = g_stage[NSTAGE-1].carry_q;

`ifdef CSEL_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Carry into the MSB is recovered from the MSB operand and sum bits.
    assign ovf_d = g_stage[NSTAGE-1].a_in[BLOCK-1] ^ g_stage[NSTAGE-1].b_in[BLOCK-1]
                 ^ g_stage[NSTAGE-1].sum_d[WIDTH-1] ^ g_stage[NSTAGE-1].carry_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed bench for csel_adder_pipe: 16/4 and 6/3 configurations, vector tables,
// back-pressure, mid-flight reset. Checks ovf when CSEL_ADDER_OVF_EN is defined.
module tb_csel_adder_pipe;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    csel_adder_pipe_if #(.WIDTH(16)) bus16 ();
    csel_adder_pipe_if #(.WIDTH(6))  bus6 ();

    csel_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
    csel_adder_pipe #(.WIDTH(6),  .BLOCK(3)) dut6  (.clk(clk), .reset(reset), .bus(bus6));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec16_t;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic       cin;
        logic [5:0] sum;
        logic       cout;
        logic       ovf;
    } vec6_t;

    localparam int N16 = 10;
    localparam int N6  = 3;

    vec16_t v16 [N16];
    vec6_t  v6  [N6];

    logic [15:0] exp_sum_q [$];
    logic        exp_cout_q [$];
    logic [15:0] held_sum;
    logic        held_cout;
    logic        held_valid;
    logic        was_stall;
    logic [16:0] full;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        op_c;
    int          sent;
    int          got;
    int          cyc;

    initial begin
        v16[0] = '{16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0};
        v16[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        v16[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        v16[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        v16[4] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        v16[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        v16[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        v16[7] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
        v16[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        v16[9] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};

        v6[0] = '{6'd57, 6'd26, 1'b1, 6'd20, 1'b1, 1'b0};
        v6[1] = '{6'd57, 6'd26, 1'b0, 6'd19, 1'b1, 1'b0};
        v6[2] = '{6'd28, 6'd11, 1'b1, 6'd40, 1'b0, 1'b1};

        reset           = 1'b1;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.cin       = 1'b0;
        bus16.out_ready = 1'b1;
        bus6.in_valid   = 1'b0;
        bus6.a          = '0;
        bus6.b          = '0;
        bus6.cin        = 1'b0;
        bus6.out_ready  = 1'b1;

        // Reset held for two edges, then the idle state after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset out_valid", bus16.out_valid, 0);
        check("reset sum", bus16.sum, 0);
        check("reset cout", bus16.cout, 0);
        check("reset in_ready", bus16.in_ready, 1);
        check("reset6 out_valid", bus6.out_valid, 0);
        check("reset6 in_ready", bus6.in_ready, 1);
`ifdef CSEL_ADDER_OVF_EN
        check("reset ovf", bus16.ovf, 0);
`endif

        // 16-bit table, back-to-back; result j-4 must be on the output at cycle j.
        for (int j = 0; j < N16 + 4; j++) begin
            @(negedge clk);
            if (j >= 4) begin
                check($sformatf("v16[%0d] out_valid", j - 4), bus16.out_valid, 1);
                check($sformatf("v16[%0d] sum", j - 4), bus16.sum, v16[j-4].sum);
                check($sformatf("v16[%0d] cout", j - 4), bus16.cout, v16[j-4].cout);
`ifdef CSEL_ADDER_OVF_EN
                check($sformatf("v16[%0d] ovf", j - 4), bus16.ovf, v16[j-4].ovf);
`endif
            end else if (j == 3) begin
                check("v16 latency early", bus16.out_valid, 0);
            end
            if (j < N16) begin
                bus16.in_valid = 1'b1;
                bus16.a        = v16[j].a;
                bus16.b        = v16[j].b;
                bus16.cin      = v16[j].cin;
            end else begin
                bus16.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("v16 drained", bus16.out_valid, 0);

        // 6-bit / 3-bit blocks: two stages of latency.
        for (int j = 0; j < N6 + 2; j++) begin
            @(negedge clk);
            if (j >= 2) begin
                check($sformatf("v6[%0d] out_valid", j - 2), bus6.out_valid, 1);
                check($sformatf("v6[%0d] sum", j - 2), bus6.sum, v6[j-2].sum);
                check($sformatf("v6[%0d] cout", j - 2), bus6.cout, v6[j-2].cout);
`ifdef CSEL_ADDER_OVF_EN
                check($sformatf("v6[%0d] ovf", j - 2), bus6.ovf, v6[j-2].ovf);
`endif
            end else if (j == 1) begin
                check("v6 latency early", bus6.out_valid, 0);
            end
            if (j < N6) begin
                bus6.in_valid = 1'b1;
                bus6.a        = v6[j].a;
                bus6.b        = v6[j].b;
                bus6.cin      = v6[j].cin;
            end else begin
                bus6.in_valid = 1'b0;
            end
        end

        // Eight back-to-back operations with out_ready low for three cycles mid-stream.
        sent      = 0;
        got       = 0;
        cyc       = 0;
        was_stall = 1'b0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            bus16.out_ready = !(cyc >= 6 && cyc < 9);
            #1;
            if (was_stall) begin
                check("stall sum stable", bus16.sum, held_sum);
                check("stall cout stable", bus16.cout, held_cout);
                check("stall valid stable", bus16.out_valid, held_valid);
            end
            if (bus16.out_valid && !bus16.out_ready) begin
                check("stall in_ready", bus16.in_ready, 0);
                held_sum   = bus16.sum;
                held_cout  = bus16.cout;
                held_valid = bus16.out_valid;
                was_stall  = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (bus16.out_valid && bus16.out_ready) begin
                if (exp_sum_q.size() == 0) begin
                    check("stall extra result", bus16.out_valid, 0);
                end else begin
                    check($sformatf("stream[%0d] sum", got), bus16.sum, exp_sum_q.pop_front());
                    check($sformatf("stream[%0d] cout", got), bus16.cout,
                          exp_cout_q.pop_front());
                    got++;
                end
            end
            if (sent < 8) begin
                op_a           = 16'(16'h2345 * (sent + 1));
                op_b           = 16'hE00F ^ 16'(sent << 4);
                op_c           = sent[0];
                bus16.in_valid = 1'b1;
                bus16.a        = op_a;
                bus16.b        = op_b;
                bus16.cin      = op_c;
                if (bus16.in_ready) begin
                    full = {1'b0, op_a} + {1'b0, op_b} + {16'h0000, op_c};
                    exp_sum_q.push_back(full[15:0]);
                    exp_cout_q.push_back(full[16]);
                    sent++;
                end
            end else begin
                bus16.in_valid = 1'b0;
            end
            cyc++;
        end
        check("stream result count", got, 8);
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stream no duplicate", bus16.out_valid, 0);
        end

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus16.in_valid = 1'b1;
            bus16.a        = 16'h1111 * 16'(i + 1);
            bus16.b        = 16'h0101;
            bus16.cin      = 1'b1;
        end
        @(negedge clk);
        bus16.in_valid = 1'b0;
        reset          = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("flush out_valid", bus16.out_valid, 0);
        check("flush sum", bus16.sum, 0);
        check("flush cout", bus16.cout, 0);
        check("flush in_ready", bus16.in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("flush quiet[%0d]", i), bus16.out_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
